huffman_ctrl: RTL and testbench
===============================

# huffman_ctrl

Sequencer for the 6-symbol Huffman coder. It counts symbol occurrences over a fixed-length input stream, then builds the Huffman tree with five merge steps and stores each step's group membership masks. It then replays the merges root-first to drive `state`, `data_l` and `data_s` into the six-cell encoder, which accumulates each symbol's HC/M code and mask registers. It also exports the per-symbol occurrence counts.

## Interface
- `N_SYMBOLS`, default 100: number of valid input samples per frame (max 127).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `gray_valid`  in  1  input sample strobe.
- `gray_data`  in  8  symbol value; only 1..6 are legal.
- `state`  out  3  current phase, drives the encoder; reset value IDLE.
- `data_l`  out  6  members of the larger group at the current split; bit5 = symbol 1 … bit0 = symbol 6; reset value 0.
- `data_s`  out  6  members of the smaller group, same bit order; reset value 0.
- `CNT1`..`CNT6`  out  8 each  occurrence count of symbols 1..6; reset value 0.
- `busy`  out  1  high in every state except IDLE; reset value 0.
- `code_valid`  out  1  one-cycle pulse in DONE; reset value 0.

## Operation
- **States:** IDLE → COUNT → COMBINE → CODEV → DECODE → DONE → IDLE. All outputs are registered.
- **IDLE:**
  - Clear CNTx, the sample counter and all merge records.
  - A legal `gray_valid` sample counts immediately and moves the FSM to COUNT.
- **COUNT:**
  - Each legal sample increments CNT[gray_data] and the 7-bit sample counter.
  - Samples outside 1..6 are ignored and do not advance the sample counter.
  - When the N_SYMBOLS-th sample is accepted, go to COMBINE.
- **COMBINE:** exactly 5 cycles, merge step k = 0..4, one step per cycle.
  - Keep six groups: weight w[i] (8-bit), member mask m[i] (6-bit), active flag.
  - Initial values: w[i] = CNT(i+1), m[i] = one-hot of symbol i+1, all groups active.
  - Each step, pick the smallest active group a and the second-smallest b.
  - Tie rule: on equal weight, the lower slot index counts as smaller.
  - Record s_mask[k] = m[a] and l_mask[k] = m[b].
  - Update slot b: w[b] = w[a] + w[b] (cannot overflow; sum ≤ 100), m[b] = m[a] | m[b].
  - Deactivate slot a.
  - Zero-weight symbols take part normally.
- **CODEV:** one cycle. `data_l` and `data_s` are 0. The encoder clears its HC and M registers.
- **DECODE:** exactly 5 cycles, k = 4 down to 0.
  - Drive `data_l` = l_mask[k] and `data_s` = s_mask[k].
  - The masks are disjoint.
  - The encoder appends 0 for members of `data_l` and 1 for members of `data_s`.
- **DONE:** one cycle. `code_valid` = 1, `data_l` and `data_s` are 0.
- Samples arriving in COMBINE, CODEV, DECODE or DONE are ignored, not buffered.
- Reset during any state returns everything to reset values on the reset edge. The encoder is cleared by its own reset.

## Timing
- `state`, `data_l` and `data_s` change on the same edge, so the encoder samples a consistent triple on the next edge.
- Last sample accepted at edge E: COMBINE covers E+1..E+5, CODEV E+6, DECODE E+7..E+11, DONE E+12, IDLE E+13.
- Encoder HC/M values are final while `code_valid` = 1.
- CNTx are final from edge E and hold their values until the FSM re-enters IDLE (they are cleared in IDLE).
- A new frame can start on the first `gray_valid` seen while in IDLE.

## Structure
- **Shared definitions header `huffman_defs`:**
  - State encodings used by the encoder: IDLE=0, COUNT=1, COMBINE=2, CODEV=3, DECODE=4, DONE=5. `DECODE` and `CODEV` are referenced by the encoder.
  - Symbol count 6.
  - Merge step count 5.
- **Sub-module `huffman_min2`:** combinational. Takes six weights plus active flags and returns indices a and b using the tie rule above. It is the only non-trivial combinational path.

## Test plan
- **Reference frame.** Counts 30,25,20,15,6,4 for symbols 1..6, in random order, 100 samples. Required:
  - DECODE (data_l, data_s) sequence: (27,18), (20,07), (10,08), (04,03), (02,01), hex.
  - Encoder at DONE: HC1..6 = 00,02,03,02,06,07; M1..6 = 03,03,03,07,0F,0F.
- **Uniform frame.** Counts 17,17,17,17,16,16. Required: first merge records s_mask=02 (symbol 5), l_mask=01 (symbol 6), confirming the tie rule; decode runs 5 steps.
- **Illegal symbols.** Interleave values 0, 7 and 255 with 100 legal samples. Required: illegal samples are not counted; CNT sum is 100; COMBINE begins only after the 100th legal sample.
- **Reset in DECODE.** Assert `reset` at E+9. Required: `state`=IDLE, `data_l`=`data_s`=0 and CNTx=0 immediately; the next full frame produces the reference-frame result.
- **Back-to-back frames.** Drive `gray_valid` continuously. Required: samples during E+1..E+12 are ignored; the next frame starts in IDLE; `code_valid` pulses once per frame, exactly 12 cycles after the last accepted sample.

Source files
------------

// File: rtl/huffman_defs.sv
// Shared definitions for the 6-symbol Huffman sequencer and its encoder.
//   state_e     : phase encoding seen on the `state` bus (encoder decodes
//                 CODEV and DECODE)
//   NUM_SYM     : number of symbols
//   NUM_STEPS   : number of merge steps (NUM_SYM - 1)
//   sym_legal() : true for symbol values 1..6
//   sym_onehot(): member-mask bit of a slot (bit5 = symbol 1)
package huffman_defs;

  localparam int NUM_SYM   = 6;
  localparam int NUM_STEPS = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    COMBINE = 3'd2,
    CODEV   = 3'd3,
    DECODE  = 3'd4,
    DONE    = 3'd5
  } state_e;

  function automatic logic sym_legal(input logic [7:0] d);
    return (d >= 8'd1) && (d <= 8'd6);
  endfunction

  function automatic logic [5:0] sym_onehot(input int slot);
    return 6'b100000 >> slot;
  endfunction

endpackage

// File: rtl/huffman_min2.sv
// Picks the two lightest active groups.
//   w_i   : six group weights
//   act_i : active flag per group
//   a_o   : slot of the smallest active group
//   b_o   : slot of the second-smallest active group
// Ordering is by weight, then by slot index, so on a tie the lower slot
// counts as smaller. Scanning upward with a strict compare gives exactly that.
module huffman_min2
  import huffman_defs::*;
(
  input  logic [NUM_SYM-1:0][7:0] w_i,
  input  logic [NUM_SYM-1:0]      act_i,
  output logic [2:0]              a_o,
  output logic [2:0]              b_o
);

  logic [2:0] idx_a, idx_b;
  logic       found_a, found_b;

  always_comb begin
    idx_a   = '0;
    idx_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (act_i[i] && (!found_a || (w_i[i] < w_i[idx_a]))) begin
        idx_a   = 3'(i);
        found_a = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SYM; i++) begin
      if (act_i[i] && (3'(i) != idx_a) && (!found_b || (w_i[i] < w_i[idx_b]))) begin
        idx_b   = 3'(i);
        found_b = 1'b1;
      end
    end
  end

  assign a_o = idx_a;
  assign b_o = idx_b;

endmodule

// File: rtl/huffman_ctrl.sv
// Sequencer for the 6-symbol Huffman coder: counts a frame of N_SYMBOLS
// legal samples, builds the tree with five merges, then replays the merges
// root-first towards the six-cell encoder.
//   clk, reset        : clock, asynchronous active-high reset
//   gray_valid/_data  : sample strobe and symbol value (1..6 legal)
//   state             : current phase, drives the encoder
//   data_l / data_s   : larger / smaller group at the current split
//   CNT1..CNT6        : per-symbol occurrence counts
//   busy              : high outside IDLE
//   code_valid        : one-cycle pulse in DONE
//
// state   | meaning
// IDLE    | counts/records cleared, first legal sample starts a frame
// COUNT   | counting legal samples until N_SYMBOLS accepted
// COMBINE | five merge steps, one per cycle, masks recorded
// CODEV   | encoder clears its HC/M registers
// DECODE  | replay merges k = 4..0 on data_l/data_s
// DONE    | code_valid pulse, encoder results final
module huffman_ctrl
  import huffman_defs::*;
#(
  parameter int N_SYMBOLS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gray_valid,
  input  logic [7:0] gray_data,
  output logic [2:0] state,
  output logic [5:0] data_l,
  output logic [5:0] data_s,
  output logic [7:0] CNT1,
  output logic [7:0] CNT2,
  output logic [7:0] CNT3,
  output logic [7:0] CNT4,
  output logic [7:0] CNT5,
  output logic [7:0] CNT6,
  output logic       busy,
  output logic       code_valid
);

  localparam logic [6:0] N_LAST = 7'(N_SYMBOLS);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  state_e                     state_q, state_d;
  logic [2:0]                 step_q, step_d;
  logic [6:0]                 smp_q, smp_d;
  logic [NUM_SYM-1:0][7:0]    cnt_q, cnt_d;
  logic [NUM_SYM-1:0][7:0]    w_q, w_d, w_cur;
  logic [NUM_SYM-1:0][5:0]    m_q, m_d, m_cur;
  logic [NUM_SYM-1:0]         act_q, act_d, act_cur;
  logic [NUM_STEPS-1:0][5:0]  smask_q, smask_d, lmask_q, lmask_d;
  logic [5:0]                 data_l_q, data_l_d, data_s_q, data_s_d;
  logic                       busy_q, code_valid_q;
  logic                       accept;
  logic [2:0]                 sym_idx;
  logic [2:0]                 idx_a, idx_b;

  assign accept  = gray_valid && sym_legal(gray_data);
  assign sym_idx = gray_data[2:0] - 3'd1;

  // Step 0 merges straight from the final counts, so the group registers
  // need no separate load cycle between COUNT and COMBINE.
  always_comb begin
    w_cur   = w_q;
    m_cur   = m_q;
    act_cur = act_q;
    if (step_q == 3'd0) begin
      w_cur   = cnt_q;
      act_cur = '1;
      for (int i = 0; i < NUM_SYM; i++) m_cur[i] = sym_onehot(i);
    end
  end

  huffman_min2 u_min2 (
    .w_i   (w_cur),
    .act_i (act_cur),
    .a_o   (idx_a),
    .b_o   (idx_b)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    m_d     = m_q;
    act_d   = act_q;
    smask_d = smask_q;
    lmask_d = lmask_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        smp_d   = '0;
        step_d  = '0;
        smask_d = '0;
        lmask_d = '0;
        if (accept) begin
          cnt_d[sym_idx] = 8'd1;
          smp_d          = 7'd1;
          state_d        = (smp_d == N_LAST) ? COMBINE : COUNT;
        end
      end
      COUNT: begin
        if (accept) begin
          cnt_d[sym_idx] = cnt_q[sym_idx] + 8'd1;
          smp_d          = smp_q + 7'd1;
          if (smp_d == N_LAST) state_d = COMBINE;
        end
      end
      COMBINE: begin
        smask_d[step_q] = m_cur[idx_a];
        lmask_d[step_q] = m_cur[idx_b];
        w_d             = w_cur;
        m_d             = m_cur;
        act_d           = act_cur;
        w_d[idx_b]      = w_cur[idx_a] + w_cur[idx_b];
        m_d[idx_b]      = m_cur[idx_a] | m_cur[idx_b];
        act_d[idx_a]    = 1'b0;
        if (step_q == LAST_STEP) begin
          state_d = CODEV;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      CODEV: begin
        state_d = DECODE;
        step_d  = LAST_STEP;
      end
      DECODE: begin
        if (step_q == 3'd0) state_d = DONE;
        else                step_d  = step_q - 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output triple is derived from the next state so state, data_l and data_s
  // all switch on the same edge.
  always_comb begin
    data_l_d = '0;
    data_s_d = '0;
    if (state_d == DECODE) begin
      data_l_d = lmask_d[step_d];
      data_s_d = smask_d[step_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      smp_q        <= '0;
      cnt_q        <= '0;
      w_q          <= '0;
      m_q          <= '0;
      act_q        <= '0;
      smask_q      <= '0;
      lmask_q      <= '0;
      data_l_q     <= '0;
      data_s_q     <= '0;
      busy_q       <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      smp_q        <= smp_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      m_q          <= m_d;
      act_q        <= act_d;
      smask_q      <= smask_d;
      lmask_q      <= lmask_d;
      data_l_q     <= data_l_d;
      data_s_q     <= data_s_d;
      busy_q       <= (state_d != IDLE);
      code_valid_q <= (state_d == DONE);
    end
  end

  assign state      = state_q;
  assign data_l     = data_l_q;
  assign data_s     = data_s_q;
  assign busy       = busy_q;
  assign code_valid = code_valid_q;
  assign CNT1       = cnt_q[0];
  assign CNT2       = cnt_q[1];
  assign CNT3       = cnt_q[2];
  assign CNT4       = cnt_q[3];
  assign CNT5       = cnt_q[4];
  assign CNT6       = cnt_q[5];

endmodule

// File: tb/tb_huffman_ctrl.sv
// Bench for huffman_ctrl: shuffled frames, a behavioural Huffman model and a
// behavioural six-cell encoder fed from the DUT outputs.
module tb_huffman_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_COMBINE = 3'd2;
  localparam logic [2:0] ST_CODEV   = 3'd3;
  localparam logic [2:0] ST_DECODE  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_valid;
  logic [7:0] gray_data;
  logic [2:0] state;
  logic [5:0] data_l, data_s;
  logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic       busy, code_valid;
  logic [7:0] cnt_obs [6];

  int n_pass  = 0;
  int n_total = 0;

  int         frame_cnt [6];
  logic [5:0] exp_l [5];
  logic [5:0] exp_s [5];
  int         exp_hc [6];
  int         exp_m [6];

  logic [7:0] hc [6];
  logic [7:0] mm [6];

  always #5 clk = ~clk;

  huffman_ctrl #(.N_SYMBOLS(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .state      (state),
    .data_l     (data_l),
    .data_s     (data_s),
    .CNT1       (CNT1),
    .CNT2       (CNT2),
    .CNT3       (CNT3),
    .CNT4       (CNT4),
    .CNT5       (CNT5),
    .CNT6       (CNT6),
    .busy       (busy),
    .code_valid (code_valid)
  );

  assign cnt_obs[0] = CNT1;
  assign cnt_obs[1] = CNT2;
  assign cnt_obs[2] = CNT3;
  assign cnt_obs[3] = CNT4;
  assign cnt_obs[4] = CNT5;
  assign cnt_obs[5] = CNT6;

  // Encoder cells: clear in CODEV, append 0 (larger group) or 1 (smaller).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        hc[i] <= '0;
        mm[i] <= '0;
      end
    end else if (state == ST_CODEV) begin
      for (int i = 0; i < 6; i++) begin
        hc[i] <= '0;
        mm[i] <= '0;
      end
    end else if (state == ST_DECODE) begin
      for (int i = 0; i < 6; i++) begin
        if (data_l[5-i]) begin
          hc[i] <= hc[i] << 1;
          mm[i] <= (mm[i] << 1) | 8'd1;
        end else if (data_s[5-i]) begin
          hc[i] <= (hc[i] << 1) | 8'd1;
          mm[i] <= (mm[i] << 1) | 8'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Huffman reference: repeatedly join the two lightest groups, ranking by
  // the key weight*8+slot so a tie goes to the lower slot.
  task automatic model();
    int         w [6];
    logic [5:0] m [6];
    bit         act [6];
    int         a, b, ka, kb, key, code, len;
    for (int i = 0; i < 6; i++) begin
      w[i]   = frame_cnt[i];
      m[i]   = 6'b100000 >> i;
      act[i] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      a = -1; b = -1; ka = 1 << 30; kb = 1 << 30;
      for (int i = 0; i < 6; i++) begin
        key = w[i] * 8 + i;
        if (act[i] && key < ka) begin
          kb = ka; b = a;
          ka = key; a = i;
        end else if (act[i] && key < kb) begin
          kb = key; b = i;
        end
      end
      exp_s[k] = m[a];
      exp_l[k] = m[b];
      w[b]     = w[b] + w[a];
      m[b]     = m[b] | m[a];
      act[a]   = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      code = 0; len = 0;
      for (int k = 4; k >= 0; k--) begin
        if (exp_l[k][5-i]) begin
          code = code * 2; len++;
        end else if (exp_s[k][5-i]) begin
          code = code * 2 + 1; len++;
        end
      end
      exp_hc[i] = code;
      exp_m[i]  = (1 << len) - 1;
    end
  endtask

  task automatic set_ref_expect();
    exp_l[4] = 6'h27; exp_s[4] = 6'h18;
    exp_l[3] = 6'h20; exp_s[3] = 6'h07;
    exp_l[2] = 6'h10; exp_s[2] = 6'h08;
    exp_l[1] = 6'h04; exp_s[1] = 6'h03;
    exp_l[0] = 6'h02; exp_s[0] = 6'h01;
    exp_hc[0] = 'h00; exp_hc[1] = 'h02; exp_hc[2] = 'h03;
    exp_hc[3] = 'h02; exp_hc[4] = 'h06; exp_hc[5] = 'h07;
    exp_m[0] = 'h03; exp_m[1] = 'h03; exp_m[2] = 'h03;
    exp_m[3] = 'h07; exp_m[4] = 'h0F; exp_m[5] = 'h0F;
  endtask

  task automatic rand_counts();
    for (int i = 0; i < 6; i++) frame_cnt[i] = 0;
    repeat (100) frame_cnt[$urandom_range(5, 0)]++;
  endtask

  task automatic set_counts(input int c0, c1, c2, c3, c4, c5);
    frame_cnt[0] = c0; frame_cnt[1] = c1; frame_cnt[2] = c2;
    frame_cnt[3] = c3; frame_cnt[4] = c4; frame_cnt[5] = c5;
  endtask

  task automatic check_cnts(input string tag);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_CNT%0d", tag, i + 1), cnt_obs[i], frame_cnt[i]);
  endtask

  // Expected outputs j cycles after the edge that accepted the last sample.
  task automatic check_cycle(input int j);
    logic [2:0] st;
    logic [5:0] dl, ds;
    st = ST_IDLE; dl = '0; ds = '0;
    if (j <= 4)       st = ST_COMBINE;
    else if (j == 5)  st = ST_CODEV;
    else if (j <= 10) begin
      st = ST_DECODE;
      dl = exp_l[10-j];
      ds = exp_s[10-j];
    end
    else if (j == 11) st = ST_DONE;
    check($sformatf("j%0d_state", j), state, st);
    check($sformatf("j%0d_data_l", j), data_l, dl);
    check($sformatf("j%0d_data_s", j), data_s, ds);
    check($sformatf("j%0d_busy", j), busy, (j < 12));
    check($sformatf("j%0d_code_valid", j), code_valid, (j == 11));
  endtask

  // Entered and left at a negedge; the first sample is driven immediately so
  // consecutive calls give a continuous stream.
  task automatic run_frame(input bit with_illegal, input bit junk_after,
                           input int reset_at, input bit use_ref);
    int samples [$];
    int list [$];
    int tmp, r, iv;
    for (int s = 0; s < 6; s++)
      for (int n = 0; n < frame_cnt[s]; n++) samples.push_back(s + 1);
    for (int i = samples.size() - 1; i > 0; i--) begin
      r = $urandom_range(i, 0);
      tmp = samples[i]; samples[i] = samples[r]; samples[r] = tmp;
    end
    for (int i = 0; i < samples.size(); i++) begin
      if (with_illegal && ($urandom_range(3, 0) == 0 || i == samples.size() - 1)) begin
        case ($urandom_range(2, 0))
          0:       iv = 0;
          1:       iv = 7;
          default: iv = 255;
        endcase
        list.push_back(iv);
      end
      list.push_back(samples[i]);
    end
    model();
    if (use_ref) set_ref_expect();

    for (int idx = 0; idx < list.size(); idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == list.size() - 1) check("pre_last_state", state, ST_COUNT);
      gray_valid = 1'b1;
      gray_data  = 8'(list[idx]);
    end

    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      check_cycle(j);
      if (j == 0)  check_cnts("final");
      if (j == 12) check_cnts("hold");
      if (j == 11) begin
        for (int i = 0; i < 6; i++) begin
          check($sformatf("HC%0d", i + 1), hc[i], exp_hc[i]);
          check($sformatf("M%0d", i + 1), mm[i], exp_m[i]);
        end
      end
      if (reset_at > 0 && j == reset_at) begin
        reset = 1'b1;
        #1;
        check("rst_state", state, ST_IDLE);
        check("rst_data_l", data_l, 6'd0);
        check("rst_data_s", data_s, 6'd0);
        check("rst_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++)
          check($sformatf("rst_CNT%0d", i + 1), cnt_obs[i], 8'd0);
        @(negedge clk);
        reset      = 1'b0;
        gray_valid = 1'b0;
        return;
      end
      if (junk_after && j < 12) begin
        gray_valid = 1'b1;
        gray_data  = 8'($urandom_range(6, 1));
      end else begin
        gray_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    gray_valid = 1'b0;
    gray_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_state", state, ST_IDLE);
    check("reset_data_l", data_l, 6'd0);
    check("reset_data_s", data_s, 6'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_code_valid", code_valid, 1'b0);
    for (int i = 0; i < 6; i++)
      check($sformatf("reset_CNT%0d", i + 1), cnt_obs[i], 8'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reference frame.
    set_counts(30, 25, 20, 15, 6, 4);
    run_frame(1'b0, 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);

    // Uniform frame: tie rule on the first merge.
    set_counts(17, 17, 17, 17, 16, 16);
    run_frame(1'b0, 1'b1, 0, 1'b0);
    check("uniform_first_s", exp_s[0], 6'h02);
    check("uniform_first_l", exp_l[0], 6'h01);

    // Illegal symbols interleaved.
    rand_counts();
    run_frame(1'b1, 1'b0, 0, 1'b0);

    // Reset in DECODE, then a clean reference frame.
    set_counts(30, 25, 20, 15, 6, 4);
    run_frame(1'b0, 1'b0, 8, 1'b1);
    set_counts(30, 25, 20, 15, 6, 4);
    run_frame(1'b0, 1'b0, 0, 1'b1);

    // Back-to-back frames with continuous gray_valid.
    for (int f = 0; f < 4; f++) begin
      rand_counts();
      run_frame(f[0], 1'b1, 0, 1'b0);
    end
    repeat (3) @(negedge clk);

    // Skewed random frames with zero-weight symbols.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6; i++) frame_cnt[i] = 0;
      frame_cnt[$urandom_range(5, 0)] = 90;
      repeat (10) frame_cnt[$urandom_range(5, 0)]++;
      run_frame(1'b0, 1'b0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
